// File: rtl/sha_pkg.sv
// Shared SHA-256 datapath constants and the rotate unit's state type.
package sha_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LOG2_WORD_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rot_state_t;

endpackage

// File: rtl/rotl_iter_unit_stage.sv
// One log-shifter stage: rotate left by 2**k when enabled, else pass through.
module rotl_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LOG2W = 5
) (
    input  logic [WIDTH-1:0] data,
    input  logic [LOG2W-1:0] k,
    input  logic             en,
    output logic [WIDTH-1:0] rot_out
);

    logic [LOG2W-1:0] lsh;
    logic [LOG2W-1:0] rsh;

    // WIDTH is a power of two, so WIDTH - 2**k is the LOG2W-bit negation of 2**k.
    always_comb begin
        lsh     = LOG2W'(1) << k;
        rsh     = LOG2W'(0) - lsh;
        rot_out = en ? ((data << lsh) | (data >> rsh)) : data;
    end

endmodule

// File: rtl/rotl_iter_unit.sv
// Iterative rotate-left unit: one log-shifter stage per clock, valid/ready on both sides.
module rotl_iter_unit
    import sha_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned LOG2W = LOG2_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    rot_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LOG2W-1:0] amt_q, amt_d;
    logic [LOG2W-1:0] k_q, k_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [LOG2W-1:0] amt_sh;
    logic             stage_en;
    logic [WIDTH-1:0] stage_out;

    always_comb begin
        amt_sh   = amt_q >> k_q;
        stage_en = amt_sh[0];
    end

    rotl_stage #(
        .WIDTH (WIDTH),
        .LOG2W (LOG2W)
    ) u_stage (
        .data    (data_q),
        .k       (k_q),
        .en      (stage_en),
        .rot_out (stage_out)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        amt_d       = amt_q;
        k_d         = k_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    amt_d      = in_amt;
                    k_d        = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                data_d = stage_out;
                if (k_q == LOG2W'(LOG2W - 1)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = stage_out;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + LOG2W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            amt_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            amt_q       <= amt_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
